mem_port_ctrl: RTL and testbench

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_port_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_port_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// Single-outstanding CPU-to-Memory port controller with keyboard-address protection
// and a bounded wait on mem_busy; every output is driven straight from a flop.
module mem_port_ctrl #(
   parameter int unsigned BUSY_TIMEOUT = 255,
   parameter logic [15:0] KBD_ADDR     = 16'h6000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_load,
   output logic [15:0] mem_address,
   output logic [15:0] mem_in,
   input  logic        mem_busy,
   input  logic [15:0] mem_out
);

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

   // The busy cycle that would bring the count up to BUSY_TIMEOUT ends the access.
   localparam logic [7:0] BusyLimit = 8'(BUSY_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        write_q, write_d;
   logic [7:0]  busy_cnt_q, busy_cnt_d;
   logic        load_q, load_d;
   logic        ready_q, ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;

   logic        handshake;
   logic        illegal;
   logic        timeout;
   logic        fail;

   assign handshake = req_valid & ready_q;
   assign illegal   = (req_addr > KBD_ADDR) | (req_write & (req_addr == KBD_ADDR));
   assign timeout   = mem_busy & (busy_cnt_q >= BusyLimit);

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         write_q     <= 1'b0;
         busy_cnt_q  <= '0;
         load_q      <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         write_q     <= write_d;
         busy_cnt_q  <= busy_cnt_d;
         load_q      <= load_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next-state logic; fail marks an entry into RESP that must report an error.
   always_comb begin
      state_d = state_q;
      fail    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (handshake) begin
               if (illegal) begin
                  state_d = StResp;
                  fail    = 1'b1;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            if (!mem_busy) begin
               state_d = write_q ? StResp : StCapture;
            end else if (timeout) begin
               state_d = StResp;
               fail    = 1'b1;
            end
         end
         StCapture: state_d = StResp;
         StResp:    state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs and datapath
   always_comb begin
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_d    = write_q;
      busy_cnt_d = busy_cnt_q;
      rdata_d    = rdata_q;

      // Illegal requests never reach the Memory pins, so the latch is skipped for them.
      if (state_q == StIdle && handshake && !illegal) begin
         addr_d     = req_addr;
         wdata_d    = req_wdata;
         write_d    = req_write;
         busy_cnt_d = '0;
      end

      if (state_q == StIssue && mem_busy && busy_cnt_q != 8'hFF) begin
         busy_cnt_d = busy_cnt_q + 8'd1;
      end

      if (state_q == StCapture) begin
         rdata_d = mem_out;
      end

      if (fail) begin
         rdata_d = '0;
      end

      load_d      = (state_d == StIssue) & write_d;
      ready_d     = (state_d == StIdle);
      rsp_valid_d = (state_d == StResp);
      rsp_err_d   = fail;
   end

   assign req_ready   = ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = rsp_err_q;
   assign mem_load    = load_q;
   assign mem_address = addr_q;
   assign mem_in      = wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl; DUT built with BUSY_TIMEOUT=4 so the
// busy timeout is reachable in a few cycles.
module tb_mem_port_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_load;
   logic [15:0] mem_address;
   logic [15:0] mem_in;
   logic        mem_busy;
   logic [15:0] mem_out;

   int n_pass  = 0;
   int n_total = 0;

   mem_port_ctrl #(
      .BUSY_TIMEOUT(4),
      .KBD_ADDR    (16'h6000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_load   (mem_load),
      .mem_address(mem_address),
      .mem_in     (mem_in),
      .mem_busy   (mem_busy),
      .mem_out    (mem_out)
   );

   always #5 clk = ~clk;

   // Each step lands 1 time unit after a rising edge: outputs are settled, inputs
   // set here are seen at the following edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request in the current cycle (T); returns in cycle T+1.
   task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
      int waited = 0;
      while (req_ready !== 1'b1 && waited < 10) begin
         step();
         waited++;
      end
      n_total++;
      if (req_ready !== 1'b1) $display("FAIL issue_ready act=%0b exp=1", req_ready);
      else n_pass++;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      step();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      mem_busy  = 1'b0;
      mem_out   = 16'hDEAD;
      step();
      step();
      n_total++;
      if ({mem_load, mem_address, mem_in} !== 33'd0)
         $display("FAIL rst_mem act=%0b/%h/%h exp=0/0000/0000", mem_load, mem_address, mem_in);
      else n_pass++;
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== 18'd0)
         $display("FAIL rst_rsp act=%0b/%0b/%h exp=0/0/0000", rsp_valid, rsp_err, rsp_rdata);
      else n_pass++;
      reset = 1'b0;
      step();
      n_total++;
      if (req_ready !== 1'b1) $display("FAIL rst_ready act=%0b exp=1", req_ready);
      else n_pass++;
   endtask

   task automatic test_reset_precedence();
      reset     = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0005;
      req_wdata = 16'h5555;
      step();
      reset     = 1'b0;
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (mem_load !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL rst_prec_c%0d act=load%0b/valid%0b exp=0/0", k, mem_load, rsp_valid);
         else n_pass++;
         step();
      end
   endtask

   task automatic test_write();
      issue(1'b1, 16'h0010, 16'h1234);
      n_total++;
      if ({mem_load, mem_address, mem_in, rsp_valid} !== {1'b1, 16'h0010, 16'h1234, 1'b0})
         $display("FAIL wr_t1 act=%0b/%h/%h/%0b exp=1/0010/1234/0", mem_load, mem_address,
                  mem_in, rsp_valid);
      else n_pass++;
      step();
      n_total++;
      if ({rsp_valid, rsp_err, mem_load, req_ready} !== 4'b1000)
         $display("FAIL wr_t2 act=%0b/%0b/%0b/%0b exp=1/0/0/0", rsp_valid, rsp_err, mem_load,
                  req_ready);
      else n_pass++;
      step();
      n_total++;
      if ({rsp_valid, rsp_err, req_ready} !== 3'b001)
         $display("FAIL wr_t3 act=%0b/%0b/%0b exp=0/0/1", rsp_valid, rsp_err, req_ready);
      else n_pass++;
   endtask

   task automatic test_read();
      issue(1'b0, 16'h0010, 16'h0000);
      mem_out = 16'hDEAD;
      n_total++;
      if ({mem_load, mem_address, rsp_valid} !== {1'b0, 16'h0010, 1'b0})
         $display("FAIL rd_t1 act=%0b/%h/%0b exp=0/0010/0", mem_load, mem_address, rsp_valid);
      else n_pass++;
      step();
      mem_out = 16'h1234;
      n_total++;
      if (rsp_valid !== 1'b0) $display("FAIL rd_t2 act=%0b exp=0", rsp_valid);
      else n_pass++;
      step();
      mem_out = 16'hBEEF;
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 16'h1234})
         $display("FAIL rd_t3 act=%0b/%0b/%h exp=1/0/1234", rsp_valid, rsp_err, rsp_rdata);
      else n_pass++;
      step();
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 16'h1234})
         $display("FAIL rd_hold act=%0b/%0b/%h exp=0/0/1234", rsp_valid, rsp_err, rsp_rdata);
      else n_pass++;
   endtask

   task automatic test_busy_write();
      issue(1'b1, 16'h4000, 16'hFFFF);
      for (int k = 1; k <= 4; k++) begin
         mem_busy = (k < 4);
         n_total++;
         if ({mem_load, mem_address, mem_in, rsp_valid} !== {1'b1, 16'h4000, 16'hFFFF, 1'b0})
            $display("FAIL busy_t%0d act=%0b/%h/%h/%0b exp=1/4000/ffff/0", k, mem_load,
                     mem_address, mem_in, rsp_valid);
         else n_pass++;
         step();
      end
      n_total++;
      if ({rsp_valid, rsp_err, mem_load} !== 3'b100)
         $display("FAIL busy_t5 act=%0b/%0b/%0b exp=1/0/0", rsp_valid, rsp_err, mem_load);
      else n_pass++;
      step();
   endtask

   task automatic test_timeout();
      int cyc = 0;
      issue(1'b1, 16'h4001, 16'h0F0F);
      mem_busy = 1'b1;
      n_total++;
      if (mem_load !== 1'b1) $display("FAIL to_load act=%0b exp=1", mem_load);
      else n_pass++;
      while (rsp_valid !== 1'b1 && cyc < 20) begin
         step();
         cyc++;
      end
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata, mem_load} !== {1'b1, 1'b1, 16'h0000, 1'b0})
         $display("FAIL to_rsp act=%0b/%0b/%h/%0b exp=1/1/0000/0", rsp_valid, rsp_err,
                  rsp_rdata, mem_load);
      else n_pass++;
      step();
      n_total++;
      if ({req_ready, mem_load, rsp_valid, rsp_err} !== 4'b1000)
         $display("FAIL to_after act=%0b/%0b/%0b/%0b exp=1/0/0/0", req_ready, mem_load,
                  rsp_valid, rsp_err);
      else n_pass++;
      mem_busy = 1'b0;
   endtask

   task automatic test_illegal();
      // Read a nonzero word first so the zeroed error data is visible.
      issue(1'b0, 16'h0020, 16'h0000);
      step();
      mem_out = 16'h5A5A;
      step();
      step();
      issue(1'b1, 16'h6000, 16'hAAAA);
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata, mem_load} !== {1'b1, 1'b1, 16'h0000, 1'b0})
         $display("FAIL ill_wr act=%0b/%0b/%h/%0b exp=1/1/0000/0", rsp_valid, rsp_err,
                  rsp_rdata, mem_load);
      else n_pass++;
      step();
      n_total++;
      if ({mem_load, rsp_valid, req_ready} !== 3'b001)
         $display("FAIL ill_wr_after act=%0b/%0b/%0b exp=0/0/1", mem_load, rsp_valid, req_ready);
      else n_pass++;
      issue(1'b0, 16'h7000, 16'h0000);
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata, mem_load} !== {1'b1, 1'b1, 16'h0000, 1'b0})
         $display("FAIL ill_rd act=%0b/%0b/%h/%0b exp=1/1/0000/0", rsp_valid, rsp_err,
                  rsp_rdata, mem_load);
      else n_pass++;
      step();
      // Reading the keyboard word itself is legal.
      issue(1'b0, 16'h6000, 16'h0000);
      step();
      mem_out = 16'h0041;
      step();
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 16'h0041})
         $display("FAIL kbd_rd act=%0b/%0b/%h exp=1/0/0041", rsp_valid, rsp_err, rsp_rdata);
      else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 16'h1000, 16'h0AAA);
      mem_busy = 1'b1;
      n_total++;
      if (mem_load !== 1'b1) $display("FAIL rmid_load act=%0b exp=1", mem_load);
      else n_pass++;
      step();
      reset = 1'b1;
      step();
      reset    = 1'b0;
      mem_busy = 1'b0;
      n_total++;
      if ({mem_load, rsp_valid, mem_address} !== {1'b0, 1'b0, 16'h0000})
         $display("FAIL rmid_clr act=%0b/%0b/%h exp=0/0/0000", mem_load, rsp_valid, mem_address);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         step();
         n_total++;
         if (mem_load !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL rmid_quiet_c%0d act=%0b/%0b exp=0/0", k, mem_load, rsp_valid);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 16'h0011, 16'hC0DE);
      n_total++;
      if ({mem_load, mem_address, mem_in} !== {1'b1, 16'h0011, 16'hC0DE})
         $display("FAIL b2b_t1 act=%0b/%h/%h exp=1/0011/c0de", mem_load, mem_address, mem_in);
      else n_pass++;
      step();
      n_total++;
      if ({rsp_valid, rsp_err} !== 2'b10)
         $display("FAIL b2b_t2 act=%0b/%0b exp=1/0", rsp_valid, rsp_err);
      else n_pass++;
      step();
   endtask

   initial begin
      test_reset();
      test_reset_precedence();
      test_write();
      test_read();
      test_busy_write();
      test_timeout();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "bench timed out");
   end

endmodule
